// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   N-input, W-bit valid/ready stream multiplexer. A round-robin arbiter picks
//   one source per beat. With LOCK=1 the grant is held from the first beat of
//   a packet until its in_last beat. Output is a single register stage.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   per-channel beat valid                    [N]
//   in_data    channel i at bits [i*W +: W]              [N*W]
//   in_last    per-channel end-of-packet                 [N]
//   in_ready   per-channel accept, one-hot or zero       [N]
//   out_valid  output register holds a beat
//   out_data   registered beat data                      [W]
//   out_last   registered end-of-packet
//   out_sel    source channel of the current beat        [SELW]
//   out_ready  downstream accept
//
// Lock FSM
//   state     | meaning
//   ST_ARB    | round-robin grant from ptr across all valid channels
//   ST_LOCKED | mid-packet; only lock_ch may be granted
module stream_mux_rr #(
    parameter  int N    = 4,
    parameter  int W    = 8,
    parameter  int LOCK = 1,
    localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      in_valid,
    input  logic [N*W-1:0]    in_data,
    input  logic [N-1:0]      in_last,
    output logic [N-1:0]      in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic              out_last,
    output logic [SELW-1:0]   out_sel,
    input  logic              out_ready
);

    typedef enum logic {ST_ARB, ST_LOCKED} state_t;

    state_t            state_q,     state_d;
    logic [SELW-1:0]   ptr_q,       ptr_d;
    logic [SELW-1:0]   lock_ch_q,   lock_ch_d;
    logic              out_valid_q, out_valid_d;
    logic [W-1:0]      out_data_q,  out_data_d;
    logic              out_last_q,  out_last_d;
    logic [SELW-1:0]   out_sel_q,   out_sel_d;

    logic              load_en;
    logic [N-1:0]      eligible;
    logic              found;
    logic [SELW-1:0]   gnt_idx;
    logic              xfer;
    logic              gnt_last;
    logic [W-1:0]      gnt_data;

    always_comb begin
        load_en = !out_valid_q || out_ready;

        // While locked, every channel except the packet owner is masked out.
        for (int i = 0; i < N; i++) begin
            eligible[i] = in_valid[i] &&
                          ((state_q == ST_ARB) || (SELW'(i) == lock_ch_q));
        end

        // Rotating priority search starting at ptr.
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            int c;
            c = int'(ptr_q) + k;
            if (c >= N) c = c - N;
            if (!found && eligible[c]) begin
                found   = 1'b1;
                gnt_idx = SELW'(c);
            end
        end

        // Reset gates the handshake so nothing is accepted while the
        // register is being cleared.
        in_ready = '0;
        if (found && load_en && !rst) in_ready[gnt_idx] = 1'b1;
        xfer     = |(in_valid & in_ready);

        gnt_last = in_last[gnt_idx];
        gnt_data = in_data[int'(gnt_idx)*W +: W];

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        if (load_en) begin
            out_valid_d = found;
            if (found) begin
                out_data_d = gnt_data;
                out_last_d = gnt_last;
                out_sel_d  = gnt_idx;
            end
        end

        ptr_d = ptr_q;
        if (xfer && ((LOCK == 0) || gnt_last)) begin
            ptr_d = (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + 1'b1;
        end

        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        if ((LOCK != 0) && xfer) begin
            if (state_q == ST_ARB && !gnt_last) begin
                state_d   = ST_LOCKED;
                lock_ch_d = gnt_idx;
            end else if (state_q == ST_LOCKED && gnt_last) begin
                state_d   = ST_ARB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ARB;
            ptr_q       <= '0;
            lock_ch_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lock_ch_q   <= lock_ch_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr. Two instances share one stimulus: index 0 is
// built with LOCK=0, index 1 with LOCK=1. A per-cycle model of the
// handshake/arbitration rules is compared against both on every negedge;
// directed sections add literal expectations for the listed scenarios.
module tb_stream_mux_rr;
    localparam int N    = 4;
    localparam int W    = 8;
    localparam int SELW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_last  = '0;
    logic [N*W-1:0] in_data  = '0;
    logic           out_ready = 1'b0;

    logic [N-1:0]    in_ready  [2];
    logic            out_valid [2];
    logic [W-1:0]    out_data  [2];
    logic            out_last  [2];
    logic [SELW-1:0] out_sel   [2];

    int n_err = 0;
    int n_chk = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    stream_mux_rr #(.N(N), .W(W), .LOCK(0)) u_nolock (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready[0]),
        .out_valid(out_valid[0]), .out_data(out_data[0]),
        .out_last(out_last[0]), .out_sel(out_sel[0]),
        .out_ready(out_ready)
    );

    stream_mux_rr #(.N(N), .W(W), .LOCK(1)) u_lock (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready[1]),
        .out_valid(out_valid[1]), .out_data(out_data[1]),
        .out_last(out_last[1]), .out_sel(out_sel[1]),
        .out_ready(out_ready)
    );

    task automatic chk(input string name, input int m,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: actual=%0h expected=%0h", name, m, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_valid  [2] = '{0, 0};
    logic [7:0] m_data   [2] = '{0, 0};
    bit         m_last   [2] = '{0, 0};
    int         m_sel    [2] = '{0, 0};
    int         m_ptr    [2] = '{0, 0};
    bit         m_locked [2] = '{0, 0};
    int         m_lch    [2] = '{0, 0};

    // Channel that would be granted if the register could load, or -1.
    function automatic int mdl_grant(input int m);
        if (m_locked[m]) return in_valid[m_lch[m]] ? m_lch[m] : -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr[m] + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            int         g;
            bit         lden;
            logic [N-1:0] er;
            g    = mdl_grant(m);
            lden = !m_valid[m] || out_ready;
            er   = '0;
            if (!rst && lden && g >= 0) er[g] = 1'b1;
            if (chk_en) begin
                chk("in_ready",  m, 32'(in_ready[m]),  32'(er));
                chk("out_valid", m, 32'(out_valid[m]), 32'(m_valid[m]));
                chk("out_data",  m, 32'(out_data[m]),  32'(m_data[m]));
                chk("out_last",  m, 32'(out_last[m]),  32'(m_last[m]));
                chk("out_sel",   m, 32'(out_sel[m]),   32'(m_sel[m]));
            end
            if (rst) begin
                m_valid[m] = 0; m_data[m] = 0; m_last[m] = 0; m_sel[m] = 0;
                m_ptr[m] = 0; m_locked[m] = 0; m_lch[m] = 0;
            end else if (lden) begin
                if (g < 0) begin
                    m_valid[m] = 0;
                end else begin
                    m_valid[m] = 1;
                    m_data[m]  = in_data[g*W +: W];
                    m_last[m]  = in_last[g];
                    m_sel[m]   = g;
                    if (m == 0 || in_last[g]) m_ptr[m] = (g + 1) % N;
                    if (m == 1) begin
                        if (!m_locked[m] && !in_last[g]) begin
                            m_locked[m] = 1;
                            m_lch[m]    = g;
                        end else if (m_locked[m] && in_last[g]) begin
                            m_locked[m] = 0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ch(input int ch, input logic [7:0] d);
        in_data[ch*W +: W] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        for (int m = 0; m < 2; m++) begin
            chk("rst_valid",    m, 32'(out_valid[m]), 0);
            chk("rst_data",     m, 32'(out_data[m]),  0);
            chk("rst_sel",      m, 32'(out_sel[m]),   0);
            chk("rst_in_ready", m, 32'(in_ready[m]),  0);
        end

        // All channels valid, single-beat packets: strict rotation 0,1,2,3,0
        for (int i = 0; i < N; i++) set_ch(i, 8'(8'hA0 + i));
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        out_ready = 1'b1;
        rst       = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                chk("rr_valid", m, 32'(out_valid[m]), 1);
                chk("rr_sel",   m, 32'(out_sel[m]),   32'(k % 4));
                chk("rr_data",  m, 32'(out_data[m]),  32'(8'hA0 + (k % 4)));
            end
        end

        // Single requester on ch2
        in_valid = 4'b0100;
        set_ch(2, 8'h5C);
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                chk("solo_sel",  m, 32'(out_sel[m]),  2);
                chk("solo_data", m, 32'(out_data[m]), 32'h5C);
            end
        end

        // Backpressure
        set_ch(2, 8'h11);
        tick();
        out_ready = 1'b0;
        set_ch(2, 8'h22);
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                chk("bp_valid", m, 32'(out_valid[m]), 1);
                chk("bp_data",  m, 32'(out_data[m]),  32'h11);
                chk("bp_ready", m, 32'(in_ready[m]),  0);
            end
        end
        out_ready = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) chk("bp_release_ready", m, 32'(in_ready[m]), 32'b0100);
        tick();
        for (int m = 0; m < 2; m++) begin
            chk("bp_next_valid", m, 32'(out_valid[m]), 1);
            chk("bp_next_data",  m, 32'(out_data[m]),  32'h22);
        end

        // Locked 3-beat packet on ch1 with ch0/ch3 competing (LOCK=1 instance)
        in_valid = 4'b0001;
        set_ch(0, 8'h30);
        tick();                                    // ch0 beat moves ptr to 1
        chk("pre_lock_sel", 1, 32'(out_sel[1]), 0);
        in_valid = 4'b1011;
        in_last  = 4'b1101;
        set_ch(1, 8'hB1);
        set_ch(3, 8'h33);
        tick();
        chk("lock_b1_sel", 1, 32'(out_sel[1]),  1);
        chk("lock_b1_dat", 1, 32'(out_data[1]), 32'hB1);
        set_ch(1, 8'hB2);
        tick();
        chk("lock_b2_sel", 1, 32'(out_sel[1]),  1);
        chk("lock_b2_dat", 1, 32'(out_data[1]), 32'hB2);
        set_ch(1, 8'hB3);
        in_last = 4'b1111;
        tick();
        chk("lock_b3_sel",  1, 32'(out_sel[1]),  1);
        chk("lock_b3_dat",  1, 32'(out_data[1]), 32'hB3);
        chk("lock_b3_last", 1, 32'(out_last[1]), 1);
        tick();
        chk("after_pkt_sel", 1, 32'(out_sel[1]), 3);
        tick();
        chk("after_pkt_sel2", 1, 32'(out_sel[1]), 0);

        // ch1 stalls mid-packet while ch0 waits
        in_valid = 4'b0011;
        in_last  = 4'b1101;
        set_ch(1, 8'hC1);
        tick();
        chk("stall_b1_sel", 1, 32'(out_sel[1]), 1);
        in_valid = 4'b0001;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("stall_valid", 1, 32'(out_valid[1]), 0);
            chk("stall_ready", 1, 32'(in_ready[1]),  0);
        end
        in_valid = 4'b0011;
        in_last  = 4'b1111;
        set_ch(1, 8'hC2);
        #1;
        chk("resume_ready", 1, 32'(in_ready[1]), 32'b0010);
        tick();
        chk("resume_sel", 1, 32'(out_sel[1]),  1);
        chk("resume_dat", 1, 32'(out_data[1]), 32'hC2);
        tick();
        chk("resume_next_sel", 1, 32'(out_sel[1]), 0);

        // Reset in the middle of a locked packet
        in_valid = 4'b0010;
        in_last  = 4'b1101;
        set_ch(1, 8'hC3);
        tick();
        chk("pre_rst_sel", 1, 32'(out_sel[1]), 1);
        rst = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) chk("rst_mid_ready", m, 32'(in_ready[m]), 0);
        tick();
        for (int m = 0; m < 2; m++) begin
            chk("rst_mid_valid", m, 32'(out_valid[m]), 0);
            chk("rst_mid_sel",   m, 32'(out_sel[m]),   0);
        end
        rst      = 1'b0;
        in_valid = 4'b1111;
        tick();
        for (int m = 0; m < 2; m++) begin
            chk("post_rst_sel",  m, 32'(out_sel[m]),  0);
            chk("post_rst_data", m, 32'(out_data[m]), 32'h30);
        end

        // Mixed traffic with irregular backpressure; model-checked only
        for (int i = 0; i < 48; i++) begin
            in_valid  = 4'((i * 5) ^ (i >> 1));
            in_last   = 4'((i * 3) + 1) | 4'((i % 7 == 0) ? 4'b1111 : 4'b0000);
            out_ready = (i % 3) != 2;
            for (int c = 0; c < N; c++) set_ch(c, 8'(i * 4 + c));
            tick();
        end
        in_valid  = '0;
        out_ready = 1'b1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-input, W-bit streaming multiplexer with valid/ready handshakes, round-robin arbitration, optional packet locking and a registered output stage. It generalises the 2:1 combinational mux: any number of sources share one sink with a fair grant policy. It sits between multiple producer channels and a single downstream consumer. It replaces the select input with an internal arbiter and reports the granted channel alongside each output beat.

## Interface
- N, 4, number of input channels (≥2)
- W, 8, data width per channel
- LOCK, 1, 1 = hold grant from first beat until the beat with in_last; 0 = re-arbitrate every beat
- SELW (localparam), $clog2(N), width of out_sel
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  N  per-channel beat valid
- in_data  in  N*W  channel i occupies bits [i*W +: W]
- in_last  in  N  per-channel end-of-packet marker
- in_ready  out  N  per-channel accept; at most one bit high in any cycle
- out_valid  out  1  output register holds a beat
- out_data  out  W  registered data
- out_last  out  1  registered last flag
- out_sel  out  SELW  channel index the current beat came from
- out_ready  in  1  downstream accept

## Operation
- Output register state:
  - load_en = !out_valid | out_ready.
  - The register loads when load_en is high and any channel is granted.
  - On load: out_data, out_last and out_sel take the granted channel's values, and out_valid = 1.
  - If load_en is high but no channel is granted, out_valid becomes 0.
- Grant is combinational. in_ready[g] = load_en & grant[g], and grant is one-hot or zero.
- A beat transfers on channel i when in_valid[i] & in_ready[i].
- Round-robin pointer ptr (SELW bits), reset 0:
  - Search order is ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - The first channel in that order with in_valid set is granted.
- Pointer update:
  - LOCK=0: after each transferred beat from channel g, ptr = (g+1) mod N. Channel N-1 wraps to 0.
  - LOCK=1: ptr updates as above only on a transferred beat with in_last=1.
- Lock FSM (LOCK=1; for LOCK=0 the FSM stays in ARB):
  - ARB: round-robin grant.
    - Transfer with in_last=0 → LOCKED, lock_ch = g.
    - Transfer with in_last=1 → stay in ARB.
  - LOCKED: only lock_ch is eligible for grant, and other channels are ignored even if valid.
    - Transfer with in_last=1 → ARB.
    - If in_valid[lock_ch] drops mid-packet, stay in LOCKED with no grant; out_valid drains to 0 once out_ready is seen.
- A single-beat packet (in_last=1 on the first beat) never enters LOCKED.
- Data on channels not granted is never sampled.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, out_sel=0, ptr=0, FSM=ARB, lock_ch=0, in_ready=0.
- Latency: a beat accepted in cycle t appears on out_* in cycle t+1.
- Throughput: 1 beat/cycle sustained when out_ready is held at 1.
- Simultaneous drain and load in the same cycle:
  - The downstream takes the old beat and the register captures the new beat.
  - out_valid stays 1, with no bubble.
- Backpressure: while out_valid=1 and out_ready=0, all in_ready are 0 and out_* hold stable.
- out_ready → in_ready is a combinational path; downstream must not derive out_ready from in_ready.
- Reset asserted mid-packet:
  - Lock, pointer and output are cleared at the next edge.
  - The in-flight output beat is discarded.
  - in_ready is 0 during reset.

## Test plan
- Reset, LOCK=0, N=4, W=8, all in_valid=1 (data 0xA0+i), out_ready=1 → out_sel sequence 0,1,2,3,0,… one per cycle; out_data 0xA0,0xA1,0xA2,0xA3; first out_valid one cycle after reset release.
- Single requester: ch2 only valid, data 0x5C, out_ready=1 → ch2 granted every cycle, out_sel=2 continuous, ptr reaches 3 after each beat and grant still returns to ch2.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1, data 0x11 → out_data holds 0x11, in_ready=0 for those cycles; on release, next beat loads the same cycle 0x11 drains.
- LOCK=1: ch1 sends 3-beat packet (last on beat 3) while ch0,ch3 also valid → three consecutive out_sel=1 beats, then ch3 granted (ptr=2 search); ch0 is not granted during the packet.
- LOCK=1: ch1 drops in_valid after beat 1 for 2 cycles while ch0 is valid → no grant to ch0, out_valid falls to 0; ch1 resumes and finishes its packet before ch0 is granted.
- Reset pulsed mid-packet under LOCK=1 → next cycle out_valid=0, FSM=ARB, ptr=0; ch0 is granted first after reset release.
